// File: rtl/packed_mac_array.sv
// packed_mac_array: LANES parallel packed MAC lanes (2x int8 or 4x int4 products
// per lane per beat), accumulated over in_last-delimited groups and handed out
// through a 2-entry result buffer with valid/ready.
// Optional feature macro: PACKED_MAC_SATURATE_EN (saturating accumulate and
// out_sat reporting); without it accumulation wraps and out_sat stays 0.
module packed_mac_array #(
  parameter int unsigned LANES = 4,
  parameter int unsigned ACC_W = 24
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [16*LANES-1:0]      in_x,
  input  logic [8*LANES-1:0]       in_y,
  input  logic                     in_mode,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [4*ACC_W*LANES-1:0] out_acc,
  output logic                     out_mode,
  output logic                     out_sat
);
  localparam int unsigned SLOTS = 4 * LANES;
  localparam int unsigned PW    = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LAST  = DEPTH - 1;
  localparam int unsigned AW    = SLOTS * ACC_W;
  localparam int unsigned PDW   = SLOTS * PW;
`ifdef PACKED_MAC_SATURATE_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

  function automatic logic [PW-1:0] smul8(input logic signed [7:0] a, input logic signed [7:0] b);
    logic signed [PW-1:0] ae, be;
    ae = PW'(a);
    be = PW'(b);
    return ae * be;
  endfunction

  function automatic logic [PW-1:0] smul4(input logic signed [3:0] a, input logic signed [3:0] b);
    logic signed [PW-1:0] ae, be;
    ae = PW'(a);
    be = PW'(b);
    return ae * be;
  endfunction

  logic                accept, last_acc, pop, push;
  logic                grp_first, grp_mode;
  logic                s0_v, s0_mode, s0_first, s0_last;
  logic [16*LANES-1:0] s0_x;
  logic [8*LANES-1:0]  s0_y;
  logic [PDW-1:0]      prod_c;
  logic [PDW-1:0]      p_data [DEPTH];
  logic [DEPTH-1:0]    p_v, p_mode, p_first, p_last;
  logic [AW-1:0]       acc, acc_nxt;
  logic                sat_grp, sat_nxt, clamp_c;
  logic signed [PW-1:0]    ps;
  logic signed [ACC_W-1:0] pe, a;
`ifdef PACKED_MAC_SATURATE_EN
  logic signed [ACC_W:0]   sum;
`endif
  logic [1:0]          pend, pend_nxt;
  logic [AW-1:0]       tail_acc;
  logic                tail_v, tail_mode, tail_sat;

  assign accept   = in_valid && in_ready;
  assign last_acc = accept && in_last;
  assign pop      = out_valid && out_ready;
  assign push     = p_v[LAST] && p_last[LAST];

  // Operand capture; group mode is latched on the first beat and reused after
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s0_v      <= 1'b0;
      s0_mode   <= 1'b0;
      s0_first  <= 1'b0;
      s0_last   <= 1'b0;
      s0_x      <= '0;
      s0_y      <= '0;
      grp_first <= 1'b1;
      grp_mode  <= 1'b0;
    end else begin
      s0_v <= accept;
      if (accept) begin
        s0_x      <= in_x;
        s0_y      <= in_y;
        s0_mode   <= grp_first ? in_mode : grp_mode;
        s0_first  <= grp_first;
        s0_last   <= in_last;
        grp_first <= in_last;
        if (grp_first) grp_mode <= in_mode;
      end
    end
  end

  // Packed per-lane products of the captured beat
  always_comb begin
    prod_c = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      if (!s0_mode) begin
        prod_c[(4*l)*PW +: PW]   = smul8(s0_x[16*l +: 8], s0_y[8*l +: 8]);
        prod_c[(4*l+1)*PW +: PW] = smul8(s0_x[16*l+8 +: 8], s0_y[8*l +: 8]);
      end else begin
        for (int s = 0; s < 4; s++)
          prod_c[(4*l+s)*PW +: PW] = smul4(s0_x[16*l+4*s +: 4], s0_y[8*l +: 4]);
      end
    end
  end

  // DSP pipeline: product register plus delay stages, control travels alongside
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_v     <= '0;
      p_mode  <= '0;
      p_first <= '0;
      p_last  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) p_data[i] <= '0;
    end else begin
      p_v     <= {p_v[DEPTH-2:0], s0_v};
      p_mode  <= {p_mode[DEPTH-2:0], s0_mode};
      p_first <= {p_first[DEPTH-2:0], s0_first};
      p_last  <= {p_last[DEPTH-2:0], s0_last};
      p_data[0] <= prod_c;
      for (int i = 1; i < int'(DEPTH); i++) p_data[i] <= p_data[i-1];
    end
  end

  // Next accumulator value: overwrite on group start, else add (clamp or wrap)
  always_comb begin
    acc_nxt = '0;
    clamp_c = 1'b0;
    ps      = '0;
    pe      = '0;
    a       = '0;
`ifdef PACKED_MAC_SATURATE_EN
    sum     = '0;
`endif
    for (int s = 0; s < int'(SLOTS); s++) begin
      ps = p_data[LAST][s*PW +: PW];
      pe = ACC_W'(ps);
      a  = acc[s*ACC_W +: ACC_W];
      if (p_first[LAST]) begin
        acc_nxt[s*ACC_W +: ACC_W] = pe;
      end else begin
`ifdef PACKED_MAC_SATURATE_EN
        sum = (ACC_W+1)'(a) + (ACC_W+1)'(pe);
        if (sum[ACC_W] != sum[ACC_W-1]) begin
          clamp_c = 1'b1;
          acc_nxt[s*ACC_W +: ACC_W] = sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
          acc_nxt[s*ACC_W +: ACC_W] = sum[ACC_W-1:0];
        end
`else
        acc_nxt[s*ACC_W +: ACC_W] = a + pe;
`endif
      end
    end
    sat_nxt = p_first[LAST] ? clamp_c : (sat_grp | clamp_c);
  end

  // Accumulator and group saturation flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc     <= '0;
      sat_grp <= 1'b0;
    end else if (p_v[LAST]) begin
      acc     <= acc_nxt;
      sat_grp <= sat_nxt;
    end
  end

  // Credit count of finished-but-unpopped groups
  always_comb begin
    pend_nxt = pend;
    if (last_acc && !pop)      pend_nxt = pend + 2'd1;
    else if (!last_acc && pop) pend_nxt = pend - 2'd1;
  end

  // Credit register; in_ready is registered so out_ready never reaches it combinationally
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend     <= 2'd0;
      in_ready <= 1'b1;
    end else begin
      pend     <= pend_nxt;
      in_ready <= (pend_nxt < 2'd2);
    end
  end

  // Two-entry result buffer: head drives out_* directly, tail holds the second entry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_mode  <= 1'b0;
      out_sat   <= 1'b0;
      tail_v    <= 1'b0;
      tail_acc  <= '0;
      tail_mode <= 1'b0;
      tail_sat  <= 1'b0;
    end else if (pop) begin
      if (tail_v) begin
        out_acc  <= tail_acc;
        out_mode <= tail_mode;
        out_sat  <= tail_sat;
        tail_v   <= push;
        if (push) begin
          tail_acc  <= acc_nxt;
          tail_mode <= p_mode[LAST];
          tail_sat  <= sat_nxt;
        end
      end else if (push) begin
        out_acc  <= acc_nxt;
        out_mode <= p_mode[LAST];
        out_sat  <= sat_nxt;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (push) begin
      if (!out_valid) begin
        out_valid <= 1'b1;
        out_acc   <= acc_nxt;
        out_mode  <= p_mode[LAST];
        out_sat   <= sat_nxt;
      end else begin
        tail_v    <= 1'b1;
        tail_acc  <= acc_nxt;
        tail_mode <= p_mode[LAST];
        tail_sat  <= sat_nxt;
      end
    end
  end

endmodule

// File: doc/packed_mac_array.md
# packed_mac_array

Parametrised mixed-precision multiply-accumulate array, successor to the single-DSP packed multiplier. Each of LANES lanes computes either two signed int8×int8 or four signed int4×int4 products per beat, packed into one DSP, and accumulates them over a group of beats delimited by `in_last`. Completed group sums go into a 2-entry result buffer with a valid/ready output. The array sits between the operand fetch stage and the requantisation stage of the OPU datapath.

## Interface
- `LANES`, 4: number of parallel lanes (one DSP each), ≥1
- `ACC_W`, 24: width of each accumulator slot, ≥16
- `clk`  in  1  clock
- `reset_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  operand beat valid
- `in_ready`  out  1  array accepts beat
- `in_x`  in  16*LANES  per-lane x operand, lane i at [16i+15:16i]
- `in_y`  in  8*LANES  per-lane shared y operand, lane i at [8i+7:8i]
- `in_mode`  in  1  0 = 2×int8×int8, 1 = 4×int4×int4; sampled on first beat of group only
- `in_last`  in  1  final beat of current group
- `out_valid`  out  1  result available
- `out_ready`  in  1  consumer takes result
- `out_acc`  out  4*ACC_W*LANES  lane i slot s at [(4i+s)*ACC_W +: ACC_W], signed
- `out_mode`  out  1  mode of the group that produced `out_acc`
- `out_sat`  out  1  any slot saturated during the group (see Configuration)

## Operation
- Beat accepted when `in_valid && in_ready`. First beat of a group = first accepted beat after reset or after a beat with `in_last=1`.
- Mode 0, lane i: slot0 = x[7:0]·y[7:0], slot1 = x[15:8]·y[7:0], all signed; slots 2,3 = 0.
- Mode 1, lane i: slot s = x[4s+3:4s]·y[3:0], signed int4, s=0..3; y[7:4] ignored.
- Products are exact (no rounding); sign-extended to ACC_W before adding.
- First beat of group overwrites accumulators with its products; later beats add. Single-beat group yields the products.
- `in_mode` on non-first beats ignored; group mode held internally.
- Bubbles (`in_valid=0`) mid-group allowed; accumulators hold.
- On the last beat's accumulate, {acc, mode, sat} pushed into the 2-entry result FIFO; head drives `out_*`; pop on `out_valid && out_ready`.
- Credit counter `pend` (0..2) = groups whose last beat is accepted but not yet popped. +1 on last-beat accept, −1 on pop, unchanged if both. `in_ready = (pend < 2) || !in_last`-independent: `in_ready = (pend < 2)`; no combinational path from `out_ready` to `in_ready`.

## Timing
- Multiply latency 4 cycles (DSP pipeline), accumulate 1 cycle.
- Last beat accepted at edge T with FIFO empty → `out_valid=1` after edge T+5.
- Throughput 1 beat/cycle per lane while `pend < 2`.
- `out_*` stable while `out_valid && !out_ready`.
- Reset (async assert, sync release): pipeline valids, accumulators, FIFO, `pend`, group-first flag cleared; `out_valid=0`, `out_acc=0`, `out_mode=0`, `out_sat=0`; `in_ready=1` first cycle after release. Partial group in flight discarded.

## Configuration
- `PACKED_MAC_SATURATE_EN` defined: each accumulate clamps to [−2^(ACC_W−1), 2^(ACC_W−1)−1]; `out_sat` = OR over all slots and beats of the group of any clamp event, cleared at group start.
- Not defined: two's-complement wrap at ACC_W bits; `out_sat` tied 0.

## Test plan
- Mode 0, lane 0, single beat x=0x807F, y=0x80 → slot0=−16256, slot1=16384, slots2/3=0, `out_valid` 5 cycles after accept.
- Mode 1, single beat x=0x8F17, y=0xA9 (y[3:0]=−7) → slots = −49, −7, 7, 56; upper y nibble has no effect.
- Mode 0, 3-beat group x=0x0102, y=0x03 each beat, one-cycle bubble between beats 2 and 3, `in_mode` toggled on beat 2 → slot0=18, slot1=9, `out_mode=0`.
- Backpressure: `out_ready=0`, send three single-beat groups back-to-back → `in_ready` low after second last-beat accept; raise `out_ready` → three results in order, `in_ready` high one cycle after first pop.
- ACC_W=16, mode 0, two beats x=0x0080, y=0x80 (16384 each): with macro slot0=32767, `out_sat=1`; without, slot0=−32768, `out_sat=0`.
- Assert `reset_n` low mid-group with one result buffered → `out_valid=0` immediately; after release, new single-beat group yields only its own products.
